// File: rtl/oled_pattern_pkg.sv
// oled_pattern_pkg: shared mode encodings, RGB565 bar palette and colour packing
// for the OLED test-pattern generator.
`default_nettype none

package oled_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_CHECKER  = 3'd0,
        MODE_BARS     = 3'd1,
        MODE_GRADIENT = 3'd2,
        MODE_SOLID    = 3'd3,
        MODE_GRID     = 3'd4
    } mode_e;

    // Index 0 is the rightmost element: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][15:0] BAR_TABLE = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    function automatic logic [7:0] pack565to332(input logic [15:0] c);
        return {c[15:13], c[10:8], c[4:3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_frame_sync.sv
// oled_frame_sync: detects the frame boundary from the row stream and advances the
// frame counter and horizontal scroll offset once per frame unless paused.
`default_nettype none

module oled_frame_sync #(
    parameter int X_SIZE     = 128,
    parameter int Y_SIZE     = 128,
    parameter int SCROLL_DIV = 2,
    localparam int XW        = $clog2(X_SIZE),
    localparam int YW        = $clog2(Y_SIZE),
    localparam int DIVW      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [YW-1:0] i_y,
    input  logic          i_pause,
    output logic          o_frame_tick,
    output logic [XW-1:0] o_offset,
    output logic [7:0]    o_frame_cnt
);

    logic [YW-1:0]   r_y_d;
    logic [DIVW-1:0] r_div;
    logic [XW-1:0]   r_offset;
    logic [7:0]      r_frame_cnt;
    logic            w_frame_tick;

    // The row wrapping from the last line back to 0 marks the end of a frame
    assign w_frame_tick = (r_y_d == YW'(Y_SIZE - 1)) && (i_y == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_y_d       <= '0;
            r_div       <= '0;
            r_offset    <= '0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_y_d <= i_y;
            if (w_frame_tick && !i_pause) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (r_div == DIVW'(SCROLL_DIV - 1)) begin
                    r_div    <= '0;
                    r_offset <= r_offset + XW'(1);
                end else begin
                    r_div <= r_div + DIVW'(1);
                end
            end
        end
    end

    assign o_frame_tick = w_frame_tick;
    assign o_offset     = r_offset;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: rtl/oled_pattern_gen.sv
// oled_pattern_gen: selectable, animated test-pattern colour source for the SPI OLED
// video path; mode changes only take effect at frame boundaries.
`default_nettype none

module oled_pattern_gen
    import oled_pattern_pkg::*;
#(
    parameter int X_SIZE     = 128,
    parameter int Y_SIZE     = 128,
    parameter int COLOR_BITS = 16,
    parameter int CELL_LOG2  = 3,
    parameter int SCROLL_DIV = 2,
    localparam int XW        = $clog2(X_SIZE),
    localparam int YW        = $clog2(Y_SIZE)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [XW-1:0]         i_x,
    input  logic [YW-1:0]         i_y,
    input  logic                  i_mode_step,
    input  logic                  i_pause,
    output logic [COLOR_BITS-1:0] o_color,
    output logic [2:0]            o_mode,
    output logic [7:0]            o_frame_cnt
);

    logic                  w_frame_tick;
    logic [XW-1:0]         w_offset;
    logic [7:0]            w_frame_cnt;
    logic [XW-1:0]         w_xs;
    logic [5:0]            w_xs_t6;
    logic [5:0]            w_y_t6;
    logic                  w_chk;
    logic                  w_x_edge;
    logic                  w_y_edge;
    logic [15:0]           w_c565;
    logic [COLOR_BITS-1:0] w_packed;
    mode_e                 w_mode_next;

    mode_e                 r_mode;
    logic                  r_pending;
    logic [COLOR_BITS-1:0] r_color;

    oled_frame_sync #(
        .X_SIZE     (X_SIZE),
        .Y_SIZE     (Y_SIZE),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_frame_sync (
        .clk          (clk),
        .resetn       (resetn),
        .i_y          (i_y),
        .i_pause      (i_pause),
        .o_frame_tick (w_frame_tick),
        .o_offset     (w_offset),
        .o_frame_cnt  (w_frame_cnt)
    );

    assign w_mode_next = (r_mode == MODE_GRID) ? MODE_CHECKER : mode_e'(r_mode + 3'd1);

    // A step arriving on the tick itself is held over so it lands on the next frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode    <= MODE_CHECKER;
            r_pending <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_pending) begin
                r_mode <= w_mode_next;
            end
            r_pending <= i_mode_step;
        end else if (i_mode_step) begin
            r_pending <= 1'b1;
        end
    end

    assign w_xs = i_x + w_offset;

    // Top six bits of each coordinate, zero-filled on the right for narrow displays
    assign w_xs_t6 = 6'({w_xs, 6'b000000} >> XW);
    assign w_y_t6  = 6'({i_y, 6'b000000} >> YW);

    assign w_chk    = w_xs[CELL_LOG2] ^ i_y[CELL_LOG2];
    assign w_x_edge = (i_x == '0) || (i_x == XW'(X_SIZE - 1)) || (i_x == XW'(X_SIZE / 2));
    assign w_y_edge = (i_y == '0) || (i_y == YW'(Y_SIZE - 1)) || (i_y == YW'(Y_SIZE / 2));

    always_comb begin
        w_c565 = 16'h0000;
        case (r_mode)
            MODE_CHECKER:  w_c565 = w_chk ? {5'd0, w_xs_t6, 5'd0} : {w_y_t6[5:1], 11'd0};
            MODE_BARS:     w_c565 = BAR_TABLE[w_xs[XW-1 -: 3]];
            MODE_GRADIENT: w_c565 = {w_xs_t6[5:1], w_y_t6, w_frame_cnt[4:0]};
            MODE_SOLID:    w_c565 = BAR_TABLE[w_frame_cnt[5:3]];
            MODE_GRID:     w_c565 = (w_x_edge || w_y_edge) ? 16'hFFFF : 16'h0000;
            default:       w_c565 = 16'h0000;
        endcase
    end

    generate
        if (COLOR_BITS == 16) begin : g_pack565
            assign w_packed = w_c565;
        end else if (COLOR_BITS == 8) begin : g_pack332
            assign w_packed = pack565to332(w_c565);
        end else begin : g_pack_bad
            $error("oled_pattern_gen: COLOR_BITS must be 8 or 16");
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_color <= '0;
        end else begin
            r_color <= w_packed;
        end
    end

    assign o_color     = r_color;
    assign o_mode      = r_mode;
    assign o_frame_cnt = w_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_oled_pattern_gen.sv
// tb_oled_pattern_gen: scoreboard bench driving a 16-bit and an 8-bit instance in
// lockstep against a behavioural model of patterns, modes and animation.
`default_nettype none

module tb_oled_pattern_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  x, y;
    logic        mode_step, pause;
    logic [15:0] color16;
    logic [7:0]  color8;
    logic [2:0]  mode16, mode8;
    logic [7:0]  fc16, fc8;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode, m_off, m_fc, m_div;
    bit m_pend;

    logic [15:0] q16[$];
    logic [7:0]  q8[$];

    always #5 clk = ~clk;

    oled_pattern_gen #(.COLOR_BITS(16)) dut16 (
        .clk(clk), .resetn(resetn), .i_x(x), .i_y(y), .i_mode_step(mode_step),
        .i_pause(pause), .o_color(color16), .o_mode(mode16), .o_frame_cnt(fc16));

    oled_pattern_gen #(.COLOR_BITS(8)) dut8 (
        .clk(clk), .resetn(resetn), .i_x(x), .i_y(y), .i_mode_step(mode_step),
        .i_pause(pause), .o_color(color8), .o_mode(mode8), .o_frame_cnt(fc8));

    function automatic logic [15:0] bar565(int i);
        case (i)
            0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;  3: return 16'h07E0;
            4: return 16'hF81F;  5: return 16'hF800;  6: return 16'h001F;  default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] model565(int md, int px, int py, int off, int fc);
        int xs, r5x, g6x, r5y, g6y;
        xs  = (px + off) % 128;
        r5x = xs * 32 / 128;  g6x = xs * 64 / 128;
        r5y = py * 32 / 128;  g6y = py * 64 / 128;
        case (md)
            0: return (((xs / 8) + (py / 8)) % 2 == 1) ? 16'(g6x * 32) : 16'(r5y * 2048);
            1: return bar565(xs / 16);
            2: return 16'(r5x * 2048 + g6y * 32 + (fc % 32));
            3: return bar565((fc / 8) % 8);
            4: return (px == 0 || px == 127 || px == 64 || py == 0 || py == 127 || py == 64)
                      ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] pack8(logic [15:0] c);
        return 8'((c / 16'd8192) * 32 + ((c / 16'd256) % 8) * 4 + ((c / 16'd8) % 4));
    endfunction

    task automatic push_pixel(int px, int py);
        logic [15:0] e;
        x = 7'(px);
        y = 7'(py);
        e = model565(m_mode, px, py, m_off, m_fc);
        q16.push_back(e);
        q8.push_back(pack8(e));
    endtask

    task automatic step_pulse();
        mode_step = 1'b1;
        @(posedge clk); #1;
        mode_step = 1'b0;
        m_pend = 1'b1;
    endtask

    task automatic frame_end(bit step);
        y = 7'd127;
        @(posedge clk); #1;
        y = 7'd0;
        mode_step = step;
        @(posedge clk); #1;
        mode_step = 1'b0;
        if (m_pend) m_mode = (m_mode == 4) ? 0 : m_mode + 1;
        m_pend = step;
        if (!pause) begin
            m_fc = (m_fc + 1) % 256;
            if (m_div == 1) begin
                m_div = 0;
                m_off = (m_off + 1) % 128;
            end else begin
                m_div = m_div + 1;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; x = '0; y = '0; mode_step = 1'b0; pause = 1'b0;
        m_mode = 0; m_off = 0; m_fc = 0; m_div = 0; m_pend = 1'b0;
        #12;
        n_tests++;
        if (color16 !== 16'h0000 || color8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_color: got %h/%h want 0000/00", color16, color8);
        end
        n_tests++;
        if (mode16 !== 3'd0 || fc16 !== 8'd0 || mode8 !== 3'd0 || fc8 !== 8'd0) begin
            n_fail++; $display("FAIL reset_state: mode %0d fc %0d want 0 0", mode16, fc16);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_checker();
        int pts[7][2] = '{'{0,0}, '{8,0}, '{0,8}, '{8,8}, '{17,3}, '{100,77}, '{127,127}};
        logic [15:0] e16;
        logic [7:0]  e8;
        foreach (pts[i]) begin
            push_pixel(pts[i][0], pts[i][1]);
            @(posedge clk); #1;
            e16 = q16.pop_front();
            e8  = q8.pop_front();
            n_tests++;
            if (color16 !== e16 || color8 !== e8) begin
                n_fail++;
                $display("FAIL checker(%0d,%0d): got %h/%h want %h/%h",
                         pts[i][0], pts[i][1], color16, color8, e16, e8);
            end
        end
    endtask

    task automatic test_mode_step();
        for (int k = 0; k < 3; k++) begin
            step_pulse();
            @(posedge clk); #1;
            n_tests++;
            if (mode16 !== 3'd0) begin
                n_fail++; $display("FAIL step_midframe%0d: mode %0d want 0", k, mode16);
            end
        end
        frame_end(1'b0);
        n_tests++;
        if (mode16 !== 3'd1 || mode8 !== 3'd1 || fc16 !== 8'd1) begin
            n_fail++; $display("FAIL step_single: mode %0d fc %0d want 1 1", mode16, fc16);
        end
    endtask

    task automatic test_bars();
        int pts[5][2] = '{'{0,5}, '{16,5}, '{127,5}, '{80,5}, '{64,40}};
        logic [15:0] e16;
        logic [7:0]  e8;
        foreach (pts[i]) begin
            push_pixel(pts[i][0], pts[i][1]);
            @(posedge clk); #1;
            e16 = q16.pop_front();
            e8  = q8.pop_front();
            n_tests++;
            if (color16 !== e16 || color8 !== e8) begin
                n_fail++;
                $display("FAIL bars(x=%0d): got %h/%h want %h/%h", pts[i][0], color16, color8, e16, e8);
            end
        end
    endtask

    task automatic test_animation();
        logic [15:0] e16;
        frame_end(1'b0);
        n_tests++;
        if (fc16 !== 8'(m_fc) || m_fc != 2) begin
            n_fail++; $display("FAIL anim_fc: got %0d want %0d", fc16, m_fc);
        end
        for (int p = 0; p < 2; p++) begin
            push_pixel(15, 0);
            @(posedge clk); #1;
            e16 = q16.pop_front();
            void'(q8.pop_front());
            n_tests++;
            if (color16 !== e16) begin
                n_fail++; $display("FAIL anim_scroll%0d: got %h want %h", p, color16, e16);
            end
            if (p == 0) begin
                pause = 1'b1;
                frame_end(1'b0);
                frame_end(1'b0);
                n_tests++;
                if (fc16 !== 8'd2) begin
                    n_fail++; $display("FAIL pause_fc: got %0d want 2", fc16);
                end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pts[6][2] = '{'{0,0}, '{64,10}, '{5,5}, '{33,127}, '{10,64}, '{99,31}};
        logic [15:0] e16;
        logic [7:0]  e8;
        step_pulse();
        frame_end(1'b1);
        n_tests++;
        if (mode16 !== 3'd2) begin
            n_fail++; $display("FAIL b2b_first: mode %0d want 2", mode16);
        end
        for (int m = 0; m < 4; m++) begin
            if (m > 0) begin
                if (m != 1) step_pulse();
                frame_end(1'b0);
            end
            n_tests++;
            if (mode16 !== 3'(m_mode) || mode8 !== 3'(m_mode)) begin
                n_fail++; $display("FAIL b2b_mode%0d: got %0d want %0d", m, mode16, m_mode);
            end
            foreach (pts[i]) begin
                push_pixel(pts[i][0], pts[i][1]);
                @(posedge clk); #1;
                e16 = q16.pop_front();
                e8  = q8.pop_front();
                n_tests++;
                if (color16 !== e16 || color8 !== e8) begin
                    n_fail++;
                    $display("FAIL mode%0d_pix(%0d,%0d): got %h/%h want %h/%h",
                             m_mode, pts[i][0], pts[i][1], color16, color8, e16, e8);
                end
            end
        end
        n_tests++;
        if (m_mode != 0 || mode16 !== 3'd0) begin
            n_fail++; $display("FAIL grid_wrap: mode %0d want 0", mode16);
        end
    endtask

    task automatic test_reset_midframe();
        step_pulse();
        frame_end(1'b0);
        x = 7'd16; y = 7'd50;
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (color16 !== 16'h0000 || color8 !== 8'h00 || mode16 !== 3'd0 || fc16 !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: color %h/%h mode %0d fc %0d want 0", color16, color8, mode16, fc16);
        end
        m_mode = 0; m_off = 0; m_fc = 0; m_div = 0; m_pend = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        frame_end(1'b0);
        n_tests++;
        if (fc16 !== 8'd1 || mode16 !== 3'd0) begin
            n_fail++; $display("FAIL post_reset_frame: fc %0d mode %0d want 1 0", fc16, mode16);
        end
    endtask

    initial begin
        test_reset();
        test_checker();
        test_mode_step();
        test_bars();
        test_animation();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
